lut_coarse_builder: RTL and testbench

//  Fills the 64-entry coarse interpolation table used by the quadratic-interpolation evaluator.
//  - Reads the 256-entry fine LUT through a synchronous read port and keeps every 4th sample.
//  - For each coarse entry i, writes the sample and its two interpolation coefficients, so the

---
 rtl/lut_coarse_builder_pkg.sv | 20 ++
 rtl/lut_coarse_builder_coef_calc.sv | 19 +
 rtl/lut_coarse_builder.sv | 117 +++++++++++
 tb/tb_lut_coarse_builder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lut_coarse_builder_pkg.sv
// Shared constants and FSM encoding for the coarse interpolation table builder.
package lut_coarse_builder_pkg;

   localparam int DATA_W    = 8;
   localparam int COARSE_AW = 6;
   localparam int DEC_SHIFT = 2;
   localparam int FINE_AW   = COARSE_AW + DEC_SHIFT;
   localparam int COARSE_N  = 1 << COARSE_AW;
   // One wrap-around sample on each side of the table: c[63] first, c[0] again last.
   localparam int RD_TOTAL  = COARSE_N + 2;
   localparam int CNT_W     = COARSE_AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } build_state_t;

endpackage

// File: rtl/lut_coarse_builder_coef_calc.sv
// Quadratic-interpolation coefficients from three neighbouring coarse samples,
// modulo 2^DATA_W.
module coarse_coef_calc
   import lut_coarse_builder_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   output logic [DATA_W-1:0] d1,
   output logic [DATA_W-1:0] d2
);

   logic [DATA_W-1:0] b_x2;

   assign b_x2 = {b[DATA_W-2:0], 1'b0};
   assign d1   = c - a;
   assign d2   = a - b_x2 + c;

endmodule

// File: rtl/lut_coarse_builder.sv
// Builds the 64-entry coarse table from every 4th fine-LUT sample, writing each
// entry together with its d1/d2 coefficients in a single pass.
module lut_coarse_builder
   import lut_coarse_builder_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 rd_en,
   output logic [FINE_AW-1:0]   rd_addr,
   input  logic [DATA_W-1:0]    rd_data,
   output logic                 wr_en,
   output logic [COARSE_AW-1:0] wr_addr,
   output logic [DATA_W-1:0]    wr_y,
   output logic [DATA_W-1:0]    wr_d1,
   output logic [DATA_W-1:0]    wr_d2
);

   build_state_t state_reg, state_next;

   logic [CNT_W-1:0]     rd_cnt_reg, rd_cnt_next;
   logic [CNT_W-1:0]     arr_cnt_reg, arr_cnt_next;
   logic                 arr_vld_reg;
   logic [DATA_W-1:0]    win_a_reg, win_a_next;
   logic [DATA_W-1:0]    win_b_reg, win_b_next;
   logic [COARSE_AW-1:0] rd_idx;
   logic [COARSE_AW-1:0] wr_idx;
   logic                 win_full;
   logic [DATA_W-1:0]    coef_d1, coef_d2;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         rd_cnt_reg  <= '0;
         arr_cnt_reg <= '0;
         arr_vld_reg <= 1'b0;
         win_a_reg   <= '0;
         win_b_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         rd_cnt_reg  <= rd_cnt_next;
         arr_cnt_reg <= arr_cnt_next;
         arr_vld_reg <= rd_en;
         win_a_reg   <= win_a_next;
         win_b_reg   <= win_b_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      rd_cnt_next  = rd_cnt_reg;
      arr_cnt_next = arr_cnt_reg;
      win_a_next   = win_a_reg;
      win_b_next   = win_b_reg;

      if (arr_vld_reg) begin
         win_a_next   = win_b_reg;
         win_b_next   = rd_data;
         arr_cnt_next = arr_cnt_reg + CNT_W'(1);
      end

      unique case (state_reg)
         IDLE: begin
            if (start) begin
               state_next   = READ;
               rd_cnt_next  = '0;
               arr_cnt_next = '0;
            end
         end
         READ: begin
            rd_cnt_next = rd_cnt_reg + CNT_W'(1);
            if (rd_cnt_reg == CNT_W'(RD_TOTAL - 1))
               state_next = DRAIN;
         end
         DRAIN: begin
            // Leave once the final sample has arrived and produced the last write.
            if (arr_vld_reg && (arr_cnt_reg == CNT_W'(RD_TOTAL - 1)))
               state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Read r fetches coarse index r-1 (mod 64), so the first read is c[63].
   assign rd_idx   = rd_cnt_reg[COARSE_AW-1:0] - COARSE_AW'(1);
   assign rd_en    = (state_reg == READ);
   assign rd_addr  = rd_en ? {rd_idx, {DEC_SHIFT{1'b0}}} : '0;

   // Arrival k completes the window centred on entry k-2, with rd_data as the newest tap.
   assign win_full = (arr_cnt_reg >= CNT_W'(2));
   assign wr_idx   = arr_cnt_reg[COARSE_AW-1:0] - COARSE_AW'(2);

   coarse_coef_calc u_coef (
      .a  (win_a_reg),
      .b  (win_b_reg),
      .c  (rd_data),
      .d1 (coef_d1),
      .d2 (coef_d2)
   );

   assign wr_en   = arr_vld_reg && win_full;
   assign wr_addr = wr_en ? wr_idx    : '0;
   assign wr_y    = wr_en ? win_b_reg : '0;
   assign wr_d1   = wr_en ? coef_d1   : '0;
   assign wr_d2   = wr_en ? coef_d2   : '0;

   assign busy = (state_reg == READ) || (state_reg == DRAIN);
   assign done = (state_reg == DONE);

endmodule

// File: tb/tb_lut_coarse_builder.sv
// Directed bench for lut_coarse_builder: fine-LUT model, write capture and protocol timing.
module tb_lut_coarse_builder;
   import lut_coarse_builder_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 busy, done, rd_en, wr_en;
   logic [FINE_AW-1:0]   rd_addr;
   logic [DATA_W-1:0]    rd_data = '0;
   logic [COARSE_AW-1:0] wr_addr;
   logic [DATA_W-1:0]    wr_y, wr_d1, wr_d2;

   lut_coarse_builder dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_y    (wr_y),
      .wr_d1   (wr_d1),
      .wr_d2   (wr_d2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Fine LUT with one cycle of read latency.
   logic [7:0] mem [256];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Monitor: counts and times every strobe relative to the accepting edge.
   int mon_gen = 0, mon_seen = 0, t_start = 0;
   int rd_cnt_m, wr_cnt_m, done_cnt_m, busy_cnt_m;
   int rd_first, rd_last, wr_first, wr_last, busy_first, busy_last, done_rel;
   logic [7:0] tab_y [64];
   logic [7:0] tab_d1 [64];
   logic [7:0] tab_d2 [64];

   always @(negedge clk) begin
      int rel;
      if (mon_gen != mon_seen) begin
         mon_seen   = mon_gen;
         rd_cnt_m   = 0; wr_cnt_m = 0; done_cnt_m = 0; busy_cnt_m = 0;
         rd_first   = -1; rd_last = -1; wr_first = -1; wr_last = -1;
         busy_first = -1; busy_last = -1; done_rel = -1;
         for (int i = 0; i < 64; i++) begin
            tab_y[i] = 'x; tab_d1[i] = 'x; tab_d2[i] = 'x;
         end
      end
      rel = cyc - t_start + 1;
      if (rd_en) begin
         check_eq("rd_addr", 32'(rd_addr), 32'(((rd_cnt_m + 63) % 64) * 4));
         if (rd_cnt_m == 0) rd_first = rel;
         rd_last = rel;
         rd_cnt_m++;
      end
      if (wr_en) begin
         check_eq("wr_addr", 32'(wr_addr), 32'(wr_cnt_m % 64));
         $display("wr t=%0d addr=%0d y=%0d d1=%0d d2=%0d", rel, wr_addr, wr_y, wr_d1, wr_d2);
         tab_y[wr_addr]  = wr_y;
         tab_d1[wr_addr] = wr_d1;
         tab_d2[wr_addr] = wr_d2;
         if (wr_cnt_m == 0) wr_first = rel;
         wr_last = rel;
         wr_cnt_m++;
      end
      if (busy) begin
         if (busy_cnt_m == 0) busy_first = rel;
         busy_last = rel;
         busy_cnt_m++;
      end
      if (done) begin
         done_cnt_m++;
         done_rel = rel;
      end
   end

   task automatic load_lut(input int mode);
      for (int i = 0; i < 256; i++) begin
         case (mode)
            0:       mem[i] = 8'(i);
            1:       mem[i] = 8'h55;
            default: mem[i] = 8'(((i >> 2) * (i >> 2)) & 255);
         endcase
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_busy"},    32'(busy),    0);
      check_eq({tag, "_done"},    32'(done),    0);
      check_eq({tag, "_rd_en"},   32'(rd_en),   0);
      check_eq({tag, "_rd_addr"}, 32'(rd_addr), 0);
      check_eq({tag, "_wr_en"},   32'(wr_en),   0);
      check_eq({tag, "_wr_addr"}, 32'(wr_addr), 0);
      check_eq({tag, "_wr_y"},    32'(wr_y),    0);
      check_eq({tag, "_wr_d1"},   32'(wr_d1),   0);
      check_eq({tag, "_wr_d2"},   32'(wr_d2),   0);
   endtask

   task automatic begin_build();
      @(negedge clk);
      mon_gen++;
      t_start = cyc + 1;
      start   = 1'b1;
   endtask

   // Fixed 100-cycle window after the start pulse; optional re-pulses while busy/done.
   task automatic run_build(input bit repulse);
      int rel;
      begin_build();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         rel   = cyc - t_start + 1;
         start = repulse && (rel == 10 || rel == 67 || rel == 68);
      end
      start = 1'b0;
   endtask

   task automatic check_protocol(input string tag);
      check_eq({tag, "_rd_count"},   rd_cnt_m,   66);
      check_eq({tag, "_rd_first"},   rd_first,   1);
      check_eq({tag, "_rd_last"},    rd_last,    66);
      check_eq({tag, "_wr_count"},   wr_cnt_m,   64);
      check_eq({tag, "_wr_first"},   wr_first,   4);
      check_eq({tag, "_wr_last"},    wr_last,    67);
      check_eq({tag, "_done_count"}, done_cnt_m, 1);
      check_eq({tag, "_done_time"},  done_rel,   68);
      check_eq({tag, "_busy_count"}, busy_cnt_m, 67);
      check_eq({tag, "_busy_first"}, busy_first, 1);
      check_eq({tag, "_busy_last"},  busy_last,  67);
      check_idle({tag, "_after"});
   endtask

   task automatic check_entry(input string tag, input int idx, input int y, input int d1, input int d2);
      check_eq({tag, "_y"},  32'(tab_y[idx]),  32'(y));
      check_eq({tag, "_d1"}, 32'(tab_d1[idx]), 32'(d1));
      check_eq({tag, "_d2"}, 32'(tab_d2[idx]), 32'(d2));
   endtask

   task automatic check_identity_table(input string tag);
      for (int i = 0; i < 64; i++) check_entry(tag, i, (i * 4) & 255, 8, 0);
   endtask

   initial begin
      int rd_hold, wr_hold;
      bit hit;
      rst   = 1'b1;
      start = 1'b0;
      load_lut(0);
      repeat (3) @(negedge clk);
      check_idle("reset");
      start = 1'b1;
      @(negedge clk);
      check_idle("reset_with_start");
      start = 1'b0;
      rst   = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("idle");

      // Identity LUT, with start re-pulsed while busy and in the done cycle.
      run_build(1'b1);
      check_protocol("ident");
      check_entry("ident_e0",  0,   0, 8, 0);
      check_entry("ident_e5",  5,  20, 8, 0);
      check_entry("ident_e63", 63, 252, 8, 0);

      // Constant LUT: every coefficient vanishes.
      load_lut(1);
      run_build(1'b0);
      check_protocol("const");
      for (int i = 0; i < 64; i++) check_entry("const", i, 8'h55, 0, 0);

      // Squares: c[i] = i*i mod 256, so c[63] = 129 and c[62] = 4.
      load_lut(2);
      run_build(1'b0);
      check_protocol("sq");
      check_entry("sq_e10", 10, 100,  40,   2);
      check_entry("sq_e0",   0,   0, 128, 130);
      check_entry("sq_e1",   1,   1,   4,   2);
      check_entry("sq_e63", 63, 129, 252,   2);

      // Reset in the middle of a build, then a full rebuild.
      load_lut(0);
      begin_build();
      @(negedge clk);
      start = 1'b0;
      hit   = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(posedge clk);
         #2;
         if (wr_cnt_m >= 30) hit = 1'b1;
      end
      check_eq("midrst_reached_30", 32'(hit), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_idle("midrst");
      rst     = 1'b0;
      rd_hold = rd_cnt_m;
      wr_hold = wr_cnt_m;
      repeat (10) @(negedge clk);
      check_eq("midrst_no_rd", rd_cnt_m, rd_hold);
      check_eq("midrst_no_wr", wr_cnt_m, wr_hold);
      check_idle("midrst_quiet");

      run_build(1'b0);
      check_protocol("rebuild");
      check_identity_table("rebuild");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
